uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter among `N_REQ` byte-stream requesters, such as the ascii sender, the watch time reporter and the echo path. A requester holds the grant for a whole message, from its first byte through the byte flagged `req_last`. The block sits between the requesters and the `uart` top. It drives `tx_start`/`tx_data` and paces bytes using `tx_busy`.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 44 ++++
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
// Shared definitions for the UART transmit arbiter:
//   state_e        - arbiter FSM states
//   N_REQ_DEFAULT  - default number of byte-stream requesters
//   PTR_W          - width of the round-robin pointer (covers up to 8 requesters)
package uart_arb_pkg;

    localparam int N_REQ_DEFAULT = 3;
    localparam int PTR_W         = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HI,
        WAIT_LO,
        NEXT
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// ptr_i and wrapping at N_REQ. Returns the first asserted request as a
// one-hot vector.
// Ports:
//   req_i   in  N_REQ  request vector
//   ptr_i   in  PTR_W  highest-priority index (must be < N_REQ)
//   pick_o  out N_REQ  one-hot winner, all zero when nothing is requested
//   any_o   out 1      at least one request is asserted
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic             any_o
);

    logic [3:0]       pos;
    logic [N_REQ-1:0] mask;

    // Walk the offsets from farthest to nearest so that the offset closest
    // to ptr_i, which is visited last, decides the winner.
    always_comb begin
        pick_o = '0;
        pos    = '0;
        mask   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_i} + 4'(k);
            if (pos >= 4'(N_REQ)) begin
                pos = pos - 4'(N_REQ);
            end
            mask = N_REQ'(1) << pos;
            if ((req_i & mask) != '0) begin
                pick_o = mask;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte-stream requesters. A
// requester keeps the grant from the first byte of its message through the
// byte flagged with req_last. Messages are granted round-robin. Bytes are
// paced by watching tx_busy rise and then fall.
// Ports:
//   clk_i        in  1        system clock
//   rst_ni       in  1        asynchronous active-low reset
//   req_valid_i  in  N_REQ    lane i holds a byte
//   req_data_i   in  8*N_REQ  byte lanes, lane i at [8i+7:8i]
//   req_last_i   in  N_REQ    lane i's byte ends its message
//   req_ready_o  out N_REQ    one-cycle pulse: lane i's byte was taken
//   grant_o      out N_REQ    one-hot current owner, zero when free
//   tx_start_o   out 1        one-cycle start pulse to the UART
//   tx_data_o    out 8        byte for the UART, held until the next accept
//   tx_busy_i    in  1        UART transmitter busy
//   arb_busy_o   out 1        arbiter is not idle
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    input  logic               tx_busy_i,
    output logic               arb_busy_o
);

    state_e           state_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] req_ready_q;
    logic             tx_start_q;
    logic [7:0]       tx_data_q;
    logic             last_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    logic [N_REQ-1:0] pickVec;
    logic             pickAny;
    logic [7:0]       pickData;
    logic             pickLast;
    logic [7:0]       ownData;
    logic             ownLast;
    logic             ownValid;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i  (req_valid_i),
        .ptr_i  (ptr_q),
        .pick_o (pickVec),
        .any_o  (pickAny)
    );

    // Two lane muxes: one for the arbitration winner while idle, one for
    // the lane that already owns the UART. The owner mux also yields the
    // pointer value that gives the owner lowest priority next time.
    always_comb begin
        pickData = '0;
        pickLast = 1'b0;
        ownData  = '0;
        ownLast  = 1'b0;
        ownValid = 1'b0;
        ptr_d    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pickVec[i]) begin
                pickData = req_data_i[8*i +: 8];
                pickLast = req_last_i[i];
            end
            if (grant_q[i]) begin
                ownData  = req_data_i[8*i +: 8];
                ownLast  = req_last_i[i];
                ownValid = req_valid_i[i];
                ptr_d    = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Arbiter FSM. req_ready and tx_start default low every cycle, so each
    // accept yields exactly one-cycle pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            last_q      <= 1'b0;
            ptr_q       <= '0;
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!tx_busy_i && pickAny) begin
                        grant_q     <= pickVec;
                        req_ready_q <= pickVec;
                        tx_start_q  <= 1'b1;
                        tx_data_q   <= pickData;
                        last_q      <= pickLast;
                        state_q     <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (tx_busy_i) begin
                        state_q <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy_i) begin
                        if (last_q) begin
                            grant_q <= '0;
                            ptr_q   <= ptr_d;
                            state_q <= IDLE;
                        end else begin
                            state_q <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    // The owner keeps the UART even if it stalls; no timeout.
                    if (ownValid) begin
                        req_ready_q <= grant_q;
                        tx_start_q  <= 1'b1;
                        tx_data_q   <= ownData;
                        last_q      <= ownLast;
                        state_q     <= WAIT_HI;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign grant_o     = grant_q;
    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign arb_busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter with three requesters. Directed
// messages are queued per lane, and the expected (lane, byte) order is
// pushed to a scoreboard. A monitor pops one entry per tx_start pulse.
module tb_uart_tx_arbiter;

    localparam int NREQ        = 3;
    localparam int BUSY_CYCLES = 4;
    localparam int DRAIN_LIMIT = 3000;

    typedef struct {
        int         lane;
        logic [7:0] data;
    } exp_t;

    logic              clk       = 1'b0;
    logic              rstN      = 1'b0;
    logic [NREQ-1:0]   reqValid  = '0;
    logic [8*NREQ-1:0] reqData   = '0;
    logic [NREQ-1:0]   reqLast   = '0;
    logic [NREQ-1:0]   reqReady;
    logic [NREQ-1:0]   grant;
    logic              txStart;
    logic [7:0]        txData;
    logic              txBusy;
    logic              arbBusy;

    logic              forceBusy = 1'b1;
    int                busyCnt   = 0;
    int                checks    = 0;
    int                errors    = 0;
    exp_t              expQ[$];
    logic [8:0]        laneQ[NREQ][$];
    logic [8:0]        headItem;
    exp_t              scoreItem;
    logic              prevStart = 1'b0;

    uart_tx_arbiter #(
        .N_REQ (NREQ)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .req_valid_i (reqValid),
        .req_data_i  (reqData),
        .req_last_i  (reqLast),
        .req_ready_o (reqReady),
        .grant_o     (grant),
        .tx_start_o  (txStart),
        .tx_data_o   (txData),
        .tx_busy_i   (txBusy),
        .arb_busy_o  (arbBusy)
    );

    always #5 clk = ~clk;

    // tx_busy is the UART model's busy window. forceBusy can also hold it high.
    assign txBusy = forceBusy || (busyCnt != 0);

    function automatic logic [NREQ-1:0] laneMask(input int lane);
        return NREQ'(1) << lane;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int lane, input logic [7:0] data, input logic last);
        laneQ[lane].push_back({last, data});
    endtask

    task automatic expectByte(input int lane, input logic [7:0] data);
        exp_t item;
        item.lane = lane;
        item.data = data;
        expQ.push_back(item);
    endtask

    function automatic bit workPending();
        bit pending = (expQ.size() != 0) || arbBusy;
        for (int i = 0; i < NREQ; i++) begin
            if (laneQ[i].size() != 0) pending = 1'b1;
        end
        return pending;
    endfunction

    // Bounded wait until every queued byte has gone out and the arbiter is idle.
    task automatic waitDone(input string name);
        int n = 0;
        while (workPending() && n < DRAIN_LIMIT) begin
            tick();
            n++;
        end
        checkOutput({name, "Timeout"}, 32'(n >= DRAIN_LIMIT), 32'd0);
        checkOutput({name, "GrantIdle"}, 32'(grant), 32'd0);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "Grant"}, 32'(grant), 32'd0);
        checkOutput({name, "Ready"}, 32'(reqReady), 32'd0);
        checkOutput({name, "Start"}, 32'(txStart), 32'd0);
        checkOutput({name, "Data"}, 32'(txData), 32'd0);
        checkOutput({name, "ArbBusy"}, 32'(arbBusy), 32'd0);
    endtask

    // UART model: busy rises on the negedge of the tx_start cycle and lasts
    // BUSY_CYCLES negedges. It clears on reset, as the real UART would.
    always @(negedge clk) begin
        if (!rstN) begin
            busyCnt = 0;
        end else begin
            if (busyCnt > 0) busyCnt = busyCnt - 1;
            if (txStart) busyCnt = BUSY_CYCLES;
        end
    end

    // Requester model: each lane presents the head of its queue. It drops the
    // head when its req_ready pulse is seen.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rstN && reqReady[i] && laneQ[i].size() > 0) begin
                void'(laneQ[i].pop_front());
            end
            if (laneQ[i].size() > 0) begin
                headItem           = laneQ[i][0];
                reqValid[i]        = 1'b1;
                reqData[8*i +: 8]  = headItem[7:0];
                reqLast[i]         = headItem[8];
            end else begin
                reqValid[i] = 1'b0;
                reqLast[i]  = 1'b0;
            end
        end
    end

    // Monitor: every tx_start pulse consumes one scoreboard entry. req_ready
    // must coincide with tx_start and match the expected lane. tx_start must
    // never last two cycles.
    always @(negedge clk) begin
        if (!rstN) begin
            prevStart = 1'b0;
        end else begin
            if (txStart) begin
                checkOutput("startWidth", 32'(prevStart), 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedStart", 32'(txData), 32'hFFFF_FFFF);
                end else begin
                    scoreItem = expQ.pop_front();
                    checkOutput("txData", 32'(txData), 32'(scoreItem.data));
                    checkOutput("grantOwner", 32'(grant), 32'(laneMask(scoreItem.lane)));
                    checkOutput("readyLane", 32'(reqReady), 32'(laneMask(scoreItem.lane)));
                end
            end else begin
                checkOutput("readyIdle", 32'(reqReady), 32'd0);
            end
            prevStart = txStart;
        end
    end

    // Watchdog against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        int n;

        // Reset values; tx_busy is held high across reset.
        repeat (3) tick();
        checkAllZero("reset");
        @(negedge clk);
        rstN = 1'b1;

        // tx_busy high after reset blocks lane 1 until it drops.
        applyStimulus(1, 8'hA5, 1'b1);
        expectByte(1, 8'hA5);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("busyBlocksStart", 32'(txStart), 32'd0);
        end
        forceBusy = 1'b0;
        tick();
        checkOutput("firstStartAfterBusy", 32'(txStart), 32'd1);
        waitDone("busyAfterReset");

        // Lane 0 sends "hi".
        applyStimulus(0, 8'h68, 1'b0);
        applyStimulus(0, 8'h69, 1'b1);
        expectByte(0, 8'h68);
        expectByte(0, 8'h69);
        waitDone("hi");

        // ptr is now 1, so lane 1 beats lane 0.
        applyStimulus(0, 8'hB0, 1'b1);
        applyStimulus(1, 8'hB1, 1'b1);
        expectByte(1, 8'hB1);
        expectByte(0, 8'hB0);
        waitDone("ptrAfterHi");

        // Lane 2 alone moves ptr back to 0.
        applyStimulus(2, 8'hC0, 1'b1);
        expectByte(2, 8'hC0);
        waitDone("lane2Alone");

        // Lanes 0 and 2 with two-byte messages; no interleaving.
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h12, 1'b1);
        applyStimulus(2, 8'h21, 1'b0);
        applyStimulus(2, 8'h22, 1'b1);
        expectByte(0, 8'h11);
        expectByte(0, 8'h12);
        expectByte(2, 8'h21);
        expectByte(2, 8'h22);
        waitDone("twoLanes");

        // All lanes, repeated one-byte messages: order 0,1,2,0,1,2.
        for (int r = 0; r < 2; r++) begin
            for (int lane = 0; lane < NREQ; lane++) begin
                applyStimulus(lane, 8'(8'hA0 + 3*r + lane), 1'b1);
                expectByte(lane, 8'(8'hA0 + 3*r + lane));
            end
        end
        waitDone("roundRobin");

        // Lane 0 stalls mid-message while lane 1 waits.
        applyStimulus(0, 8'h31, 1'b0);
        applyStimulus(1, 8'h41, 1'b1);
        expectByte(0, 8'h31);
        expectByte(0, 8'h32);
        expectByte(0, 8'h33);
        expectByte(1, 8'h41);
        n = 0;
        while (laneQ[0].size() != 0 && n < DRAIN_LIMIT) begin
            tick();
            n++;
        end
        checkOutput("stallFirstByteTimeout", 32'(n >= DRAIN_LIMIT), 32'd0);
        repeat (8) tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("stallArbBusy", 32'(arbBusy), 32'd1);
            checkOutput("stallGrant", 32'(grant), 32'(laneMask(0)));
            checkOutput("stallNoStart", 32'(txStart), 32'd0);
        end
        applyStimulus(0, 8'h32, 1'b0);
        applyStimulus(0, 8'h33, 1'b1);
        waitDone("stall");

        // Reset during WAIT_LO of byte 2 of 3; byte 3 becomes a new message.
        applyStimulus(0, 8'h51, 1'b0);
        applyStimulus(0, 8'h52, 1'b0);
        applyStimulus(0, 8'h53, 1'b1);
        expectByte(0, 8'h51);
        expectByte(0, 8'h52);
        expectByte(0, 8'h53);
        n = 0;
        while (laneQ[0].size() != 1 && n < DRAIN_LIMIT) begin
            tick();
            n++;
        end
        checkOutput("midResetReachTimeout", 32'(n >= DRAIN_LIMIT), 32'd0);
        tick();
        checkOutput("midResetInWaitLo", 32'(txBusy), 32'd1);
        rstN = 1'b0;
        #1;
        checkAllZero("midReset");
        repeat (2) tick();
        @(negedge clk);
        rstN = 1'b1;
        waitDone("afterMidReset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
